// File: rtl/fex7rank.sv
// Sequential ranker for permutations of {0..7}: produces factorial-expansion digits f1..f7
// and the packed rank sum(fK*K!), one digit per clock, seven clocks per result.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last completed run
// RUN   | one digit per clock, k counting 7 down to 1
module fex7rank #(
   parameter int RANK_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        p0,
   input  logic [2:0]        p1,
   input  logic [2:0]        p2,
   input  logic [2:0]        p3,
   input  logic [2:0]        p4,
   input  logic [2:0]        p5,
   input  logic [2:0]        p6,
   input  logic [2:0]        p7,
   output logic              busy,
   output logic              done,
   output logic              f1,
   output logic [1:0]        f2,
   output logic [1:0]        f3,
   output logic [2:0]        f4,
   output logic [2:0]        f5,
   output logic [2:0]        f6,
   output logic [2:0]        f7,
   output logic [RANK_W-1:0] rank,
   output logic              perm_err
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [2:0]        a_q [8];
   logic [2:0]        a_d [8];
   logic [2:0]        k_q, k_d;
   logic [RANK_W-1:0] acc_q, acc_d;
   logic              err_q, err_d;

   // working digits, kept private until the run completes
   logic [2:0]        d7_q, d7_d, d6_q, d6_d, d5_q, d5_d, d4_q, d4_d;
   logic [1:0]        d3_q, d3_d, d2_q, d2_d;

   logic              f1_q, f1_d;
   logic [1:0]        f2_q, f2_d, f3_q, f3_d;
   logic [2:0]        f4_q, f4_d, f5_q, f5_d, f6_q, f6_d, f7_q, f7_d;
   logic [RANK_W-1:0] rank_q, rank_d;
   logic              perm_err_q, perm_err_d;
   logic              done_q, done_d;

   logic [2:0]        q_idx;
   logic              found;
   logic [2:0]        fk;
   logic [RANK_W-1:0] acc_step;

   always_comb begin
      q_idx = 3'd0;
      found = 1'b0;
      // descending scan so the lowest matching index wins
      for (int i = 7; i >= 0; i--) begin
         if ((3'(i) <= k_q) && (a_q[i] == k_q)) begin
            q_idx = 3'(i);
            found = 1'b1;
         end
      end
      fk       = found ? (k_q - q_idx) : 3'd0;
      acc_step = (acc_q * (RANK_W'({1'b0, k_q}) + RANK_W'(1))) + RANK_W'(fk);
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      k_d        = k_q;
      acc_d      = acc_q;
      err_d      = err_q;
      d7_d       = d7_q;
      d6_d       = d6_q;
      d5_d       = d5_q;
      d4_d       = d4_q;
      d3_d       = d3_q;
      d2_d       = d2_q;
      f1_d       = f1_q;
      f2_d       = f2_q;
      f3_d       = f3_q;
      f4_d       = f4_q;
      f5_d       = f5_q;
      f6_d       = f6_q;
      f7_d       = f7_q;
      rank_d     = rank_q;
      perm_err_d = perm_err_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d[0]  = p0;
               a_d[1]  = p1;
               a_d[2]  = p2;
               a_d[3]  = p3;
               a_d[4]  = p4;
               a_d[5]  = p5;
               a_d[6]  = p6;
               a_d[7]  = p7;
               k_d     = 3'd7;
               acc_d   = '0;
               err_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (found) begin
               a_d[q_idx] = a_q[k_q];
               a_d[k_q]   = a_q[q_idx];
            end else begin
               err_d = 1'b1;
            end
            acc_d = acc_step;
            case (k_q)
               3'd7:    d7_d = fk;
               3'd6:    d6_d = fk;
               3'd5:    d5_d = fk;
               3'd4:    d4_d = fk;
               3'd3:    d3_d = fk[1:0];
               3'd2:    d2_d = fk[1:0];
               default: ;
            endcase
            if (k_q == 3'd1) begin
               f1_d       = fk[0];
               f2_d       = d2_q;
               f3_d       = d3_q;
               f4_d       = d4_q;
               f5_d       = d5_q;
               f6_d       = d6_q;
               f7_d       = d7_q;
               rank_d     = acc_step;
               perm_err_d = err_q | ~found;
               done_d     = 1'b1;
               state_d    = S_IDLE;
            end else begin
               k_d = k_q - 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < 8; i++) a_q[i] <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         err_q      <= 1'b0;
         d7_q       <= '0;
         d6_q       <= '0;
         d5_q       <= '0;
         d4_q       <= '0;
         d3_q       <= '0;
         d2_q       <= '0;
         f1_q       <= 1'b0;
         f2_q       <= '0;
         f3_q       <= '0;
         f4_q       <= '0;
         f5_q       <= '0;
         f6_q       <= '0;
         f7_q       <= '0;
         rank_q     <= '0;
         perm_err_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         err_q      <= err_d;
         d7_q       <= d7_d;
         d6_q       <= d6_d;
         d5_q       <= d5_d;
         d4_q       <= d4_d;
         d3_q       <= d3_d;
         d2_q       <= d2_d;
         f1_q       <= f1_d;
         f2_q       <= f2_d;
         f3_q       <= f3_d;
         f4_q       <= f4_d;
         f5_q       <= f5_d;
         f6_q       <= f6_d;
         f7_q       <= f7_d;
         rank_q     <= rank_d;
         perm_err_q <= perm_err_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q == S_RUN);
   assign done     = done_q;
   assign f1       = f1_q;
   assign f2       = f2_q;
   assign f3       = f3_q;
   assign f4       = f4_q;
   assign f5       = f5_q;
   assign f6       = f6_q;
   assign f7       = f7_q;
   assign rank     = rank_q;
   assign perm_err = perm_err_q;

endmodule
